// File: rtl/game_pkg.sv
`default_nettype none
// ===== game_pkg -- round sequencer state enum, default parameters, score helper (rev 1.0) =====
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SPAWN     = 3'd1,
    ST_ACTIVE    = 3'd2,
    ST_DUCK_DONE = 3'd3,
    ST_ROUND_END = 3'd4,
    ST_FINISHED  = 3'd5
  } state_t;

  localparam int DEF_DUCKS_PER_ROUND = 10;
  localparam int DEF_AMMO_PER_DUCK   = 3;
  localparam int DEF_ROUNDS          = 5;
  localparam int DEF_MIN_HITS        = 6;
  localparam int DEF_POINTS_PER_HIT  = 100;

  localparam int SCORE_W = 16;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  // Score never wraps: a long game pins at the maximum instead.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[SCORE_W] ? SCORE_MAX : sum[SCORE_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/game_round_ctrl_if.sv
`default_nettype none
// ===== game_round_ctrl_if -- game control, mouse, duck block and HUD signals (rev 1.0) =====
interface game_round_ctrl_if;
  import game_pkg::*;

  logic               game_enable;
  logic               game_enable_posedge;
  logic               left_mouse;
  logic               duck_hit;
  logic               duck_escaped;
  logic               spawn_duck;
  logic               shot;
  logic               out_of_ammo;
  logic [1:0]         ammo;
  logic [3:0]         round_num;
  logic [3:0]         round_hits;
  logic [SCORE_W-1:0] score;
  logic               game_finished;

  modport master (
    output game_enable, game_enable_posedge, left_mouse, duck_hit, duck_escaped,
    input  spawn_duck, shot, out_of_ammo, ammo, round_num, round_hits, score, game_finished
  );

  modport slave (
    input  game_enable, game_enable_posedge, left_mouse, duck_hit, duck_escaped,
    output spawn_duck, shot, out_of_ammo, ammo, round_num, round_hits, score, game_finished
  );

endinterface
`default_nettype wire

// File: rtl/click_edge_detect.sv
`default_nettype none
// ===== click_edge_detect -- rising-edge detector for the mouse button level (rev 1.0) =====
module click_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic click_prev;

  always_ff @(posedge clk) begin
    if (rst) click_prev <= 1'b0;
    else     click_prev <= in;
  end

  assign rise = in & ~click_prev;

endmodule
`default_nettype wire

// File: rtl/game_round_ctrl.sv
`default_nettype none
// ===== game_round_ctrl -- Duck Hunt round, ammo and score sequencer (rev 1.0) =====
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int DUCKS_PER_ROUND = DEF_DUCKS_PER_ROUND,
  parameter int AMMO_PER_DUCK   = DEF_AMMO_PER_DUCK,
  parameter int ROUNDS          = DEF_ROUNDS,
  parameter int MIN_HITS        = DEF_MIN_HITS,
  parameter int POINTS_PER_HIT  = DEF_POINTS_PER_HIT
) (
  input  logic             clk,
  input  logic             rst,
  game_round_ctrl_if.slave bus
);

  localparam logic [1:0]         AMMO_LOAD   = 2'(AMMO_PER_DUCK);
  localparam logic [3:0]         LAST_DUCK   = 4'(DUCKS_PER_ROUND - 1);
  localparam logic [3:0]         LAST_ROUND  = 4'(ROUNDS);
  localparam logic [3:0]         HITS_NEEDED = 4'(MIN_HITS);
  localparam logic [SCORE_W-1:0] HIT_POINTS  = SCORE_W'(POINTS_PER_HIT);

  state_t             state;
  state_t             state_next;
  logic               click;
  logic               in_play;
  logic               game_over;
  logic               spawn_duck;
  logic               shot;
  logic               game_finished;
  logic [1:0]         ammo;
  logic [3:0]         round_num;
  logic [3:0]         round_hits;
  logic [3:0]         duck_idx;
  logic [SCORE_W-1:0] score;

  click_edge_detect u_click (
    .clk  (clk),
    .rst  (rst),
    .in   (bus.left_mouse),
    .rise (click)
  );

  assign in_play   = (state == ST_SPAWN) || (state == ST_ACTIVE) ||
                     (state == ST_DUCK_DONE) || (state == ST_ROUND_END);
  assign game_over = (round_hits < HITS_NEEDED) || (round_num == LAST_ROUND);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (bus.game_enable_posedge) state_next = ST_SPAWN;
      ST_SPAWN:     state_next = ST_ACTIVE;
      // duck_hit and duck_escaped in the same cycle both lead here; the datapath scores the hit.
      ST_ACTIVE:    if (bus.duck_hit || bus.duck_escaped) state_next = ST_DUCK_DONE;
      ST_DUCK_DONE: state_next = (duck_idx == LAST_DUCK) ? ST_ROUND_END : ST_SPAWN;
      ST_ROUND_END: state_next = game_over ? ST_FINISHED : ST_SPAWN;
      ST_FINISHED:  if (bus.game_enable_posedge) state_next = ST_SPAWN;
      default:      state_next = ST_IDLE;
    endcase
    if (in_play && !bus.game_enable) state_next = ST_IDLE;
  end

  // Pulses and levels are set from the upcoming state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      spawn_duck    <= 1'b0;
      shot          <= 1'b0;
      game_finished <= 1'b0;
      ammo          <= 2'd0;
      round_num     <= 4'd0;
      round_hits    <= 4'd0;
      duck_idx      <= 4'd0;
      score         <= '0;
    end else begin
      spawn_duck    <= (state_next == ST_SPAWN);
      game_finished <= (state_next == ST_FINISHED);
      shot          <= 1'b0;
      if (state_next == ST_SPAWN) ammo <= AMMO_LOAD;
      case (state)
        ST_IDLE, ST_FINISHED: begin
          if (state_next == ST_SPAWN) begin
            score      <= '0;
            round_hits <= 4'd0;
            round_num  <= 4'd1;
            duck_idx   <= 4'd0;
          end
        end
        ST_ACTIVE: begin
          if (bus.game_enable) begin
            if (click && (ammo != 2'd0)) begin
              shot <= 1'b1;
              ammo <= ammo - 2'd1;
            end
            if (bus.duck_hit) begin
              round_hits <= round_hits + 4'd1;
              score      <= sat_add(score, HIT_POINTS);
            end
          end
        end
        ST_DUCK_DONE: if (state_next == ST_SPAWN) duck_idx <= duck_idx + 4'd1;
        ST_ROUND_END: begin
          if (state_next == ST_SPAWN) begin
            round_num  <= round_num + 4'd1;
            round_hits <= 4'd0;
            duck_idx   <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.spawn_duck    = spawn_duck;
  assign bus.shot          = shot;
  assign bus.game_finished = game_finished;
  assign bus.ammo          = ammo;
  assign bus.round_num     = round_num;
  assign bus.round_hits    = round_hits;
  assign bus.score         = score;
  assign bus.out_of_ammo   = (state == ST_ACTIVE) && (ammo == 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_game_round_ctrl.sv
`default_nettype none
// ===== tb_game_round_ctrl -- randomized scoreboard bench for game_round_ctrl (rev 1.0) =====
module tb_game_round_ctrl;
  import game_pkg::*;

  localparam int D  = 10;
  localparam int A  = 3;
  localparam int R  = 5;
  localparam int MH = 6;
  localparam int P  = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  game_round_ctrl_if bus ();

  game_round_ctrl #(
    .DUCKS_PER_ROUND (D),
    .AMMO_PER_DUCK   (A),
    .ROUNDS          (R),
    .MIN_HITS        (MH),
    .POINTS_PER_HIT  (P)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { int cyc; int rn; int rh; int sc; int am; } spawn_t;
  typedef struct { int cyc; int am; } shot_t;
  typedef struct { int cyc; int rn; int rh; int sc; } fin_t;

  spawn_t exp_spawn[$];
  shot_t  exp_shot[$];
  fin_t   exp_fin[$];

  // Game-level reference state: what the HUD should show and when the next event is due.
  int m_round, m_hits, m_score, m_duck, m_ammo, m_spawn, m_fin_cyc;
  bit m_done;

  task automatic check(input bit ok, input string name, input string detail);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  logic   prev_fin = 1'b0;
  spawn_t es;
  shot_t  eh;
  fin_t   ef;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.spawn_duck) begin
        if (exp_spawn.size() == 0)
          check(1'b0, "spawn_unexpected", $sformatf("spawn_duck at cycle %0d, none required", cyc));
        else begin
          es = exp_spawn.pop_front();
          check(cyc == es.cyc && int'(bus.round_num) == es.rn && int'(bus.round_hits) == es.rh &&
                int'(bus.score) == es.sc && int'(bus.ammo) == es.am && !bus.game_finished,
                "spawn",
                $sformatf("got cyc=%0d round=%0d hits=%0d score=%0d ammo=%0d fin=%0d, required cyc=%0d round=%0d hits=%0d score=%0d ammo=%0d fin=0",
                          cyc, bus.round_num, bus.round_hits, bus.score, bus.ammo, bus.game_finished,
                          es.cyc, es.rn, es.rh, es.sc, es.am));
        end
      end
      if (bus.shot) begin
        if (exp_shot.size() == 0)
          check(1'b0, "shot_unexpected", $sformatf("shot at cycle %0d ammo=%0d, none required", cyc, bus.ammo));
        else begin
          eh = exp_shot.pop_front();
          check(cyc == eh.cyc && int'(bus.ammo) == eh.am, "shot",
                $sformatf("got cyc=%0d ammo=%0d, required cyc=%0d ammo=%0d", cyc, bus.ammo, eh.cyc, eh.am));
        end
      end
      if (bus.game_finished && !prev_fin) begin
        if (exp_fin.size() == 0)
          check(1'b0, "finish_unexpected", $sformatf("game_finished rose at cycle %0d", cyc));
        else begin
          ef = exp_fin.pop_front();
          check(cyc == ef.cyc && int'(bus.round_num) == ef.rn && int'(bus.round_hits) == ef.rh &&
                int'(bus.score) == ef.sc, "finish",
                $sformatf("got cyc=%0d round=%0d hits=%0d score=%0d, required cyc=%0d round=%0d hits=%0d score=%0d",
                          cyc, bus.round_num, bus.round_hits, bus.score, ef.cyc, ef.rn, ef.rh, ef.sc));
        end
      end
    end
    prev_fin = bus.game_finished;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game();
    bus.game_enable         = 1'b1;
    bus.game_enable_posedge = 1'b1;
    m_round = 1; m_hits = 0; m_score = 0; m_duck = 0; m_ammo = A; m_done = 1'b0;
    m_spawn = cyc + 1;
    exp_spawn.push_back('{m_spawn, 1, 0, 0, A});
    tick();
    bus.game_enable_posedge = 1'b0;
  endtask

  task automatic wait_active();
    while (cyc < m_spawn + 1) tick();
  endtask

  task automatic click();
    bus.left_mouse = 1'b1;
    if (m_ammo > 0) begin
      m_ammo--;
      exp_shot.push_back('{cyc + 1, m_ammo});
    end
    tick();
    bus.left_mouse = 1'b0;
    tick();
  endtask

  // kind: 0 hit, 1 escape, 2 hit and escape together
  task automatic resolve(input int kind);
    int k;
    k = cyc;
    bus.duck_hit     = (kind != 1);
    bus.duck_escaped = (kind != 0);
    if (kind != 1) begin
      m_hits++;
      m_score = (m_score + P > 65535) ? 65535 : m_score + P;
    end
    if (m_duck == D - 1) begin
      if (m_hits < MH || m_round == R) begin
        m_done    = 1'b1;
        m_fin_cyc = k + 3;
        exp_fin.push_back('{k + 3, m_round, m_hits, m_score});
      end else begin
        m_round++; m_hits = 0; m_duck = 0; m_spawn = k + 3;
      end
    end else begin
      m_duck++;
      m_spawn = k + 2;
    end
    if (!m_done) begin
      m_ammo = A;
      exp_spawn.push_back('{m_spawn, m_round, m_hits, m_score, A});
    end
    tick();
    bus.duck_hit     = 1'b0;
    bus.duck_escaped = 1'b0;
  endtask

  task automatic play_duck(input int kind, input int nclicks);
    wait_active();
    repeat (nclicks) click();
    check(bus.out_of_ammo == (m_ammo == 0), "out_of_ammo",
          $sformatf("got %0d with %0d shots left, required %0d", bus.out_of_ammo, m_ammo, (m_ammo == 0)));
    resolve(kind);
  endtask

  task automatic wait_finish();
    while (cyc <= m_fin_cyc) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int hl, el, r;
    bus.game_enable = 1'b0; bus.game_enable_posedge = 1'b0; bus.left_mouse = 1'b0;
    bus.duck_hit = 1'b0; bus.duck_escaped = 1'b0;
    repeat (3) tick();
    check(bus.score == 16'd0 && bus.round_num == 4'd0 && bus.round_hits == 4'd0 && bus.ammo == 2'd0,
          "reset_counters", $sformatf("got score=%0d round=%0d hits=%0d ammo=%0d, required all 0",
                                      bus.score, bus.round_num, bus.round_hits, bus.ammo));
    check(!bus.spawn_duck && !bus.shot && !bus.out_of_ammo && !bus.game_finished, "reset_flags",
          $sformatf("got spawn=%0d shot=%0d ooa=%0d fin=%0d, required all 0",
                    bus.spawn_duck, bus.shot, bus.out_of_ammo, bus.game_finished));
    rst = 1'b0;
    tick();

    // Full pass: every duck hit, including one duck that burns four clicks.
    start_game();
    play_duck(0, 4);
    while (!m_done) play_duck(0, $urandom_range(0, 2));
    wait_finish();
    bus.game_enable = 1'b0;
    repeat (3) tick();
    check(bus.game_finished && bus.score == 16'd5000 && bus.round_num == 4'd5, "finished_hold",
          $sformatf("got fin=%0d score=%0d round=%0d, required fin=1 score=5000 round=5",
                    bus.game_finished, bus.score, bus.round_num));

    // Random game restarted straight from FINISHED.
    start_game();
    while (!m_done) begin
      r = $urandom_range(0, 9);
      play_duck((r < 6) ? 0 : (r < 7) ? 2 : 1, $urandom_range(0, 4));
    end
    wait_finish();

    // Round 1 with only five hits ends the game.
    start_game();
    hl = 5; el = 5;
    while (hl + el > 0) begin
      if (hl > 0 && (el == 0 || $urandom_range(0, 1) == 1)) begin
        hl--; play_duck(0, $urandom_range(0, 4));
      end else begin
        el--; play_duck(1, $urandom_range(0, 4));
      end
    end
    wait_finish();
    repeat (10) tick();
    check(bus.game_finished && bus.score == 16'd500 && bus.round_num == 4'd1, "fail_round1",
          $sformatf("got fin=%0d score=%0d round=%0d, required fin=1 score=500 round=1",
                    bus.game_finished, bus.score, bus.round_num));

    // Abort mid-duck with the gun empty, then restart.
    start_game();
    play_duck(0, 1);
    wait_active();
    repeat (3) click();
    check(bus.out_of_ammo == 1'b1, "ooa_empty", $sformatf("got %0d, required 1", bus.out_of_ammo));
    bus.game_enable = 1'b0;
    tick();
    check(bus.out_of_ammo == 1'b0, "abort_ooa", $sformatf("got %0d, required 0", bus.out_of_ammo));
    bus.left_mouse = 1'b1; tick(); bus.left_mouse = 1'b0;
    repeat (4) tick();
    check(bus.score == 16'd100 && bus.round_num == 4'd1 && bus.round_hits == 4'd1, "abort_hold",
          $sformatf("got score=%0d round=%0d hits=%0d, required 100/1/1",
                    bus.score, bus.round_num, bus.round_hits));
    start_game();
    play_duck(2, $urandom_range(0, 4));
    wait_active();
    check(bus.score == 16'd100 && bus.round_hits == 4'd1, "both_is_hit",
          $sformatf("got score=%0d hits=%0d, required 100/1", bus.score, bus.round_hits));
    bus.game_enable = 1'b0;
    repeat (5) tick();

    check(exp_spawn.size() == 0 && exp_shot.size() == 0 && exp_fin.size() == 0, "queues_drained",
          $sformatf("got spawn=%0d shot=%0d fin=%0d outstanding, required 0",
                    exp_spawn.size(), exp_shot.size(), exp_fin.size()));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
